uart_rx_line_buf: RTL and testbench

Line-assembly buffer on the receive side of the UART path, the counterpart to the transmit print buffer. It takes bytes from the buart receiver, applies simple line editing (backspace, escape-cancel), and stores printable characters until a carriage return. It then presents the completed line to the application, which drains it one byte per request. While a line is held or being drained, the block drops incoming bytes and flags each dropped byte.

---
 rtl/uart_rx_line_buf_if.sv | 29 ++
 rtl/uart_rx_line_buf.sv | 127 ++++++++++++
 tb/tb_uart_rx_line_buf.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_line_buf_if.sv
// Bundle of receive-byte, read-request and line-status signals for uart_rx_line_buf.
// The master drives bytes and read requests. The slave, the line buffer, drives line status and read data.
interface uart_rx_line_buf_if #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) ();
  // rxDataValid: one-cycle strobe, with no back-pressure; rxdata is valid only when it is high.
  // rdReq: level request, one byte per cycle. rdValid is high the cycle after an accepted rdReq.
  logic [7:0]  rxdata;
  logic        rxDataValid;
  logic        rdReq;
  logic        lineRdy;
  logic [AW:0] lineLen;
  logic [7:0]  rdata;
  logic        rdValid;
  logic        lineDone;
  logic        overflow;
  logic        rxDrop;

  modport master (
    output rxdata, rxDataValid, rdReq,
    input  lineRdy, lineLen, rdata, rdValid, lineDone, overflow, rxDrop
  );

  modport slave (
    input  rxdata, rxDataValid, rdReq,
    output lineRdy, lineLen, rdata, rdValid, lineDone, overflow, rxDrop
  );
endinterface

// File: rtl/uart_rx_line_buf.sv
// Receive-side line assembler: edits incoming UART bytes into a line and presents it on CR.
// The application drains the line one byte per request. Bytes that arrive while a line is held are dropped.
module uart_rx_line_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 resetB,
  uart_rx_line_buf_if.slave    bus,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  state_e      state_q, state_d;
  logic [AW:0] count_q, count_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rd_valid_q, rd_valid_d;
  logic        line_done_q, line_done_d;
  logic        rx_drop_q, rx_drop_d;
  logic        mem_we;
  logic [7:0]  mem_q [DEPTH];

  logic is_print, is_bs, is_esc, is_cr;
  assign is_print = (bus.rxdata >= 8'h20) && (bus.rxdata <= 8'h7E);
  assign is_bs    = (bus.rxdata == 8'h08) || (bus.rxdata == 8'h7F);
  assign is_esc   = (bus.rxdata == 8'h1B);
  assign is_cr    = (bus.rxdata == 8'h0D);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    rdata_d     = rdata_q;
    rd_valid_d  = 1'b0;
    line_done_d = 1'b0;
    rx_drop_d   = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      COLLECT: begin
        if (bus.rxDataValid) begin
          if (is_print) begin
            if (count_q < DEPTH_C) begin
              mem_we  = 1'b1;
              count_d = count_q + ONE_C;
            end else begin
              overflow_d = 1'b1;
            end
          end else if (is_bs) begin
            if (count_q != '0) count_d = count_q - ONE_C;
          end else if (is_esc) begin
            count_d    = '0;
            overflow_d = 1'b0;
          end else if (is_cr) begin
            // An empty line is never presented.
            if (count_q != '0) state_d = HOLD;
          end
        end
      end
      HOLD, DRAIN: begin
        rx_drop_d = bus.rxDataValid;
        if (bus.rdReq && (rd_ptr_q < count_q)) begin
          rdata_d    = mem_q[rd_ptr_q[AW-1:0]];
          rd_valid_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + ONE_C;
          state_d    = DRAIN;
          // The final byte of the line releases the buffer on the same edge.
          if (rd_ptr_q == (count_q - ONE_C)) begin
            line_done_d = 1'b1;
            count_d     = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            state_d     = COLLECT;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      state_q     <= COLLECT;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      rdata_q     <= 8'h00;
      rd_valid_q  <= 1'b0;
      line_done_q <= 1'b0;
      rx_drop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      rdata_q     <= rdata_d;
      rd_valid_q  <= rd_valid_d;
      line_done_q <= line_done_d;
      rx_drop_q   <= rx_drop_d;
    end
  end

  // The storage array has no reset; stale entries beyond count are never read.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[count_q[AW-1:0]] <= bus.rxdata;
  end

  assign bus.lineRdy  = (state_q != COLLECT);
  assign bus.lineLen  = count_q;
  assign bus.rdata    = rdata_q;
  assign bus.rdValid  = rd_valid_q;
  assign bus.lineDone = line_done_q;
  assign bus.overflow = overflow_q;
  assign bus.rxDrop   = rx_drop_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_uart_rx_line_buf.sv
// Bench for uart_rx_line_buf: fixed vector table, hand sequences for fill, escape and reset,
// then random traffic checked against a queue-based line model.
module tb_uart_rx_line_buf;

  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);

  logic       clk;
  logic       resetB;
  logic [1:0] state_dbg;

  uart_rx_line_buf_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_line_buf #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetB    (resetB),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // A line is a queue of characters. "held" means a completed line is owned by the reader.
  bit         m_held;
  bit         m_ovf;
  logic [7:0] m_line[$];
  int         m_rd;
  logic       e_valid, e_done, e_drop;
  logic [7:0] e_rdata;

  task automatic model_reset();
    m_held = 0; m_ovf = 0; m_line.delete(); m_rd = 0;
    e_valid = 0; e_done = 0; e_drop = 0; e_rdata = 8'h00;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic rq);
    e_valid = 0; e_done = 0; e_drop = 0;
    if (!m_held) begin
      if (v) begin
        if (d >= 8'h20 && d <= 8'h7E) begin
          if (m_line.size() < DEPTH) m_line.push_back(d);
          else m_ovf = 1;
        end else if (d == 8'h08 || d == 8'h7F) begin
          if (m_line.size() > 0) void'(m_line.pop_back());
        end else if (d == 8'h1B) begin
          m_line.delete(); m_ovf = 0;
        end else if (d == 8'h0D) begin
          if (m_line.size() > 0) m_held = 1;
        end
      end
    end else begin
      e_drop = v;
      if (rq && m_rd < m_line.size()) begin
        e_valid = 1;
        e_rdata = m_line[m_rd];
        m_rd++;
        if (m_rd == m_line.size()) begin
          e_done = 1; m_line.delete(); m_rd = 0; m_ovf = 0; m_held = 0;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic apply(input logic v, input logic [7:0] d, input logic rq);
    bus.rxDataValid = v;
    bus.rxdata      = d;
    bus.rdReq       = rq;
    @(posedge clk);
    model_step(v, d, rq);
    #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) apply(1'b1, 8'(s[i]), 1'b0);
  endtask

  // ---------------- scoreboard ----------------
  function automatic logic [20:0] pack(logic rdy, int len, logic val, logic [7:0] rd,
                                       logic done, logic ovf, logic drop);
    return {rdy, 8'(len), val, (val ? rd : 8'h00), done, ovf, drop};
  endfunction

  function automatic logic [20:0] dut_pack();
    return pack(bus.lineRdy, int'(bus.lineLen), bus.rdValid, bus.rdata,
                bus.lineDone, bus.overflow, bus.rxDrop);
  endfunction

  function automatic logic [20:0] model_pack();
    return pack(m_held, m_line.size(), e_valid, e_rdata, e_done, m_ovf, e_drop);
  endfunction

  task automatic compare(input string name, input logic [20:0] got, input logic [20:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {rdy,len,val,rdata,done,ovf,drop}=%h expected %h", name, got, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rq;
    logic       rdy;
    int         len;
    logic       val;
    logic [7:0] rdata;
    logic       done;
    logic       ovf;
    logic       drop;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [7:0] d, input logic rq, input logic rdy,
                     input int len, input logic val, input logic [7:0] rd,
                     input logic done, input logic ovf, input logic drop);
    vec_t t;
    t.v = v; t.d = d; t.rq = rq; t.rdy = rdy; t.len = len; t.val = val;
    t.rdata = rd; t.done = done; t.ovf = ovf; t.drop = drop;
    tbl.push_back(t);
  endtask

  task automatic rand_phase(input int n, input int cr_pct);
    logic       v, rq;
    logic [7:0] d;
    int         r;
    for (int i = 0; i < n; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      rq = ($urandom_range(0, 2) == 0);
      r  = $urandom_range(0, 99);
      if (r < cr_pct)            d = 8'h0D;
      else if (r < cr_pct + 6)   d = ($urandom_range(0, 1) != 0) ? 8'h08 : 8'h7F;
      else if (r < cr_pct + 8)   d = 8'h1B;
      else if (r < cr_pct + 10)  d = 8'h0A;
      else if (r < cr_pct + 13)  d = 8'($urandom_range(0, 255));
      else                       d = 8'($urandom_range(8'h20, 8'h7E));
      apply(v, d, rq);
      compare("random", dut_pack(), model_pack());
    end
  endtask

  logic [7:0] fill[70];

  initial begin
    bus.rxDataValid = 1'b0;
    bus.rxdata      = 8'h00;
    bus.rdReq       = 1'b0;
    resetB          = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 resetB = 1'b1;
    compare("reset_outputs", dut_pack(), 21'h0);
    compare("reset_rdata_state", {11'h0, bus.rdata, state_dbg}, 21'h0);

    // "ab" CR, drain two bytes
    add(1, 8'h61, 0, 0, 1, 0, 8'h00, 0, 0, 0);
    add(1, 8'h62, 0, 0, 2, 0, 8'h00, 0, 0, 0);
    add(1, 8'h0D, 0, 1, 2, 0, 8'h00, 0, 0, 0);
    add(0, 8'h00, 1, 1, 2, 1, 8'h61, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 1, 8'h62, 1, 0, 0);
    add(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    // "abc" BS "d" CR, drain
    add(1, 8'h61, 0, 0, 1, 0, 8'h00, 0, 0, 0);
    add(1, 8'h62, 0, 0, 2, 0, 8'h00, 0, 0, 0);
    add(1, 8'h63, 0, 0, 3, 0, 8'h00, 0, 0, 0);
    add(1, 8'h08, 0, 0, 2, 0, 8'h00, 0, 0, 0);
    add(1, 8'h64, 0, 0, 3, 0, 8'h00, 0, 0, 0);
    add(1, 8'h0D, 0, 1, 3, 0, 8'h00, 0, 0, 0);
    add(0, 8'h00, 1, 1, 3, 1, 8'h61, 0, 0, 0);
    add(0, 8'h00, 1, 1, 3, 1, 8'h62, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 1, 8'h64, 1, 0, 0);
    // "q" CR, "w" dropped while held, then drain
    add(1, 8'h71, 0, 0, 1, 0, 8'h00, 0, 0, 0);
    add(1, 8'h0D, 0, 1, 1, 0, 8'h00, 0, 0, 0);
    add(1, 8'h77, 0, 1, 1, 0, 8'h00, 0, 0, 1);
    add(0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 1, 8'h71, 1, 0, 0);
    add(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    // rdReq in COLLECT, CR on empty line, LF ignored
    add(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    add(1, 8'h0D, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    add(1, 8'h0A, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    // byte arriving on the final read edge is dropped
    add(1, 8'h6D, 0, 0, 1, 0, 8'h00, 0, 0, 0);
    add(1, 8'h0D, 0, 1, 1, 0, 8'h00, 0, 0, 0);
    add(1, 8'h6E, 1, 0, 0, 1, 8'h6D, 1, 0, 1);
    add(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0);

    foreach (tbl[i]) begin
      apply(tbl[i].v, tbl[i].d, tbl[i].rq);
      compare($sformatf("table[%0d]", i), dut_pack(),
              pack(tbl[i].rdy, tbl[i].len, tbl[i].val, tbl[i].rdata,
                   tbl[i].done, tbl[i].ovf, tbl[i].drop));
    end

    // 70 printable bytes overflow a 64-entry line
    for (int i = 0; i < 70; i++) begin
      fill[i] = 8'($urandom_range(8'h20, 8'h7E));
      apply(1'b1, fill[i], 1'b0);
    end
    compare("fill_overflow", dut_pack(), pack(0, 64, 0, 0, 0, 1, 0));
    apply(1'b1, 8'h0D, 1'b0);
    compare("fill_cr", dut_pack(), pack(1, 64, 0, 0, 0, 1, 0));
    for (int i = 0; i < 64; i++) begin
      apply(1'b0, 8'h00, 1'b1);
      compare($sformatf("fill_drain[%0d]", i), dut_pack(),
              pack(i < 63, (i < 63) ? 64 : 0, 1, fill[i], i == 63, i < 63, 0));
    end
    apply(1'b0, 8'h00, 1'b0);
    compare("fill_after_done", dut_pack(), pack(0, 0, 0, 0, 0, 0, 0));

    // backspace at full keeps overflow, ESC clears it
    for (int i = 0; i < 65; i++) apply(1'b1, 8'h41, 1'b0);
    apply(1'b1, 8'h7F, 1'b0);
    compare("bs_at_full", dut_pack(), pack(0, 63, 0, 0, 0, 1, 0));
    apply(1'b1, 8'h42, 1'b0);
    compare("refill_full", dut_pack(), pack(0, 64, 0, 0, 0, 1, 0));
    apply(1'b1, 8'h1B, 1'b0);
    compare("esc_clears", dut_pack(), pack(0, 0, 0, 0, 0, 0, 0));

    // "xy" ESC CR is ignored, then "z" CR
    send_str("xy");
    apply(1'b1, 8'h1B, 1'b0);
    apply(1'b1, 8'h0D, 1'b0);
    compare("esc_then_cr", dut_pack(), pack(0, 0, 0, 0, 0, 0, 0));
    send_str("z");
    apply(1'b1, 8'h0D, 1'b0);
    compare("z_line", dut_pack(), pack(1, 1, 0, 0, 0, 0, 0));
    apply(1'b0, 8'h00, 1'b1);
    compare("z_drain", dut_pack(), pack(0, 0, 1, 8'h7A, 1, 0, 0));

    // reset mid-drain
    send_str("hello");
    apply(1'b1, 8'h0D, 1'b0);
    apply(1'b0, 8'h00, 1'b1);
    apply(1'b0, 8'h00, 1'b1);
    compare("pre_reset", dut_pack(), pack(1, 5, 1, 8'h65, 0, 0, 0));
    bus.rdReq = 1'b0;
    resetB = 1'b0;
    #1;
    model_reset();
    compare("async_reset", dut_pack(), 21'h0);
    compare("async_reset_rdata", {11'h0, bus.rdata, state_dbg}, 21'h0);
    @(posedge clk);
    #1 resetB = 1'b1;
    send_str("k");
    apply(1'b1, 8'h0D, 1'b0);
    compare("post_reset_line", dut_pack(), pack(1, 1, 0, 0, 0, 0, 0));
    apply(1'b0, 8'h00, 1'b1);
    compare("post_reset_drain", dut_pack(), pack(0, 0, 1, 8'h6B, 1, 0, 0));

    // random traffic: long lines first, then short lines
    rand_phase(3000, 1);
    rand_phase(3000, 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
